// File: rtl/multicycle_control_fsm_if.sv
// Unified memory port between the multi-cycle controller and the memory.
// The controller drives the request side; the memory answers with mem_ready.
//   mem_req       request an access this cycle
//   mem_we        1=store, 0=read; meaningful only while mem_req=1
//   mem_addr_sel  address source: 0=PC, 1=alu_out register
//   mem_ready     memory completes the access on this cycle's rising edge
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main controller of the multi-cycle RV32I core. One instruction at a time is
// walked through FETCH, DECODE and a short opcode-specific tail that shares a
// single ALU and a single memory port.
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode            IR[6:0], stable from DECODE until the return to FETCH
//   branch_taken      branch comparator result, used in BRANCH
//   bus               memory port (master side: mem_req/mem_we/mem_addr_sel out, mem_ready in)
//   ir_write          load IR from memory read data
//   pc_write, pc_src  PC update strobe / source (00 PC+4, 01 alu_out, 10 live ALU & ~1)
//   reg_write, wb_sel register-file write strobe / source (00 alu_out, 01 MDR, 10 PC+4)
//   alu_op            ALU control (00 funct3 I-type, 10 R-type, 01 SUB, 11 ADD)
//   alu_src_a/_b      ALU operand selects (a: 00 rs1, 01 PC, 10 zero; b: 00 rs2, 01 imm, 10 4)
//   instret           one-cycle pulse when an instruction retires
//   illegal_instr     sticky, unknown opcode seen in DECODE
//   bus_error         sticky, memory did not answer within MEM_TIMEOUT wait cycles
//   state_o           current state for debug
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [6:0]                       opcode,
  input  logic                             branch_taken,
  multicycle_control_fsm_if.master         bus,
  output logic                             ir_write,
  output logic                             pc_write,
  output logic [1:0]                       pc_src,
  output logic                             reg_write,
  output logic [1:0]                       wb_sel,
  output logic [1:0]                       alu_op,
  output logic [1:0]                       alu_src_a,
  output logic [1:0]                       alu_src_b,
  output logic                             instret,
  output logic                             illegal_instr,
  output logic                             bus_error,
  output logic [3:0]                       state_o
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_EXEC_U   = 4'd4,
    ST_ALU_WB   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_ACC  = 4'd7,
    ST_LOAD_WB  = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Counter wide enough to hold MEM_TIMEOUT itself.
  localparam int unsigned        CNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit                 TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             illegal_r;
  logic             bus_err_r;
  logic             timeout_s;

  logic       mem_req_s, mem_we_s, mem_addr_sel_s, ir_write_s, pc_write_s;
  logic       reg_write_s, instret_s;
  logic [1:0] pc_src_s, wb_sel_s, alu_op_s, alu_src_a_s, alu_src_b_s;

  // The wait that would bring the count up to MEM_TIMEOUT is the last one tolerated;
  // a mem_ready in that same cycle is checked first and wins.
  assign timeout_s = TO_EN && (wait_cnt_r == TO_LAST);

  // State register, memory wait counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= '0;
      illegal_r  <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            state_r    <= ST_DECODE;
            wait_cnt_r <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            if (timeout_s) begin
              state_r   <= ST_TRAP;
              bus_err_r <= 1'b1;
            end
          end
        end
        ST_DECODE: begin
          case (opcode)
            OP_R:              state_r <= ST_EXEC_R;
            OP_I:              state_r <= ST_EXEC_I;
            OP_LUI, OP_AUIPC:  state_r <= ST_EXEC_U;
            OP_LOAD, OP_STORE: state_r <= ST_MEM_ADDR;
            OP_BRANCH:         state_r <= ST_BRANCH;
            OP_JAL:            state_r <= ST_JAL;
            OP_JALR:           state_r <= ST_JALR;
            default: begin
              state_r   <= ST_TRAP;
              illegal_r <= 1'b1;
            end
          endcase
        end
        ST_EXEC_R, ST_EXEC_I, ST_EXEC_U: state_r <= ST_ALU_WB;
        ST_MEM_ADDR:                     state_r <= ST_MEM_ACC;
        ST_MEM_ACC: begin
          if (bus.mem_ready) begin
            // opcode[5] separates store (1) from load (0)
            state_r    <= opcode[5] ? ST_FETCH : ST_LOAD_WB;
            wait_cnt_r <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            if (timeout_s) begin
              state_r   <= ST_TRAP;
              bus_err_r <= 1'b1;
            end
          end
        end
        ST_ALU_WB, ST_LOAD_WB, ST_BRANCH, ST_JAL, ST_JALR: state_r <= ST_FETCH;
        ST_TRAP:  state_r <= ST_TRAP;
        // unused encodings are treated as a fault
        default:  state_r <= ST_TRAP;
      endcase
    end
  end

  // Per-state decode of datapath controls and memory request.
  always_comb begin
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_sel_s = 1'b0;
    ir_write_s     = 1'b0;
    pc_write_s     = 1'b0;
    pc_src_s       = 2'b00;
    reg_write_s    = 1'b0;
    wb_sel_s       = 2'b00;
    alu_op_s       = 2'b00;
    alu_src_a_s    = 2'b00;
    alu_src_b_s    = 2'b00;
    instret_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req_s  = 1'b1;
        ir_write_s = bus.mem_ready;
      end
      ST_DECODE: begin
        // PC+imm precomputed into alu_out for branches and JAL
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b11;
      end
      ST_EXEC_R: alu_op_s = 2'b10;
      ST_EXEC_I: alu_src_b_s = 2'b01;
      ST_EXEC_U: begin
        alu_src_a_s = opcode[5] ? 2'b10 : 2'b01;  // LUI adds to zero, AUIPC to PC
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b11;
      end
      ST_ALU_WB: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        instret_s   = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b11;
      end
      ST_MEM_ACC: begin
        mem_req_s      = 1'b1;
        mem_addr_sel_s = 1'b1;
        mem_we_s       = opcode[5];
        pc_write_s     = bus.mem_ready & opcode[5];
        instret_s      = bus.mem_ready & opcode[5];
      end
      ST_LOAD_WB: begin
        reg_write_s = 1'b1;
        wb_sel_s    = 2'b01;
        pc_write_s  = 1'b1;
        instret_s   = 1'b1;
      end
      ST_BRANCH: begin
        alu_op_s   = 2'b01;
        pc_write_s = 1'b1;
        pc_src_s   = branch_taken ? 2'b01 : 2'b00;
        instret_s  = 1'b1;
      end
      ST_JAL: begin
        reg_write_s = 1'b1;
        wb_sel_s    = 2'b10;
        pc_write_s  = 1'b1;
        pc_src_s    = 2'b01;
        instret_s   = 1'b1;
      end
      ST_JALR: begin
        // rd gets the old PC+4 on the same edge the PC moves, so rd==rs1 is safe
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b11;
        reg_write_s = 1'b1;
        wb_sel_s    = 2'b10;
        pc_write_s  = 1'b1;
        pc_src_s    = 2'b10;
        instret_s   = 1'b1;
      end
      default: mem_req_s = 1'b0;  // TRAP and unused encodings: everything idle
    endcase
  end

  // rst_n gates every output so a reset mid-access drops mem_req immediately.
  assign bus.mem_req      = rst_n & mem_req_s;
  assign bus.mem_we       = rst_n & mem_we_s;
  assign bus.mem_addr_sel = rst_n & mem_addr_sel_s;
  assign ir_write         = rst_n & ir_write_s;
  assign pc_write         = rst_n & pc_write_s;
  assign pc_src           = {2{rst_n}} & pc_src_s;
  assign reg_write        = rst_n & reg_write_s;
  assign wb_sel           = {2{rst_n}} & wb_sel_s;
  assign alu_op           = {2{rst_n}} & alu_op_s;
  assign alu_src_a        = {2{rst_n}} & alu_src_a_s;
  assign alu_src_b        = {2{rst_n}} & alu_src_b_s;
  assign instret          = rst_n & instret_s;
  assign illegal_instr    = rst_n & illegal_r;
  assign bus_error        = rst_n & bus_err_r;
  assign state_o          = {4{rst_n}} & state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. The driver issues instructions with
// chosen memory wait counts and pushes what the instruction should look like
// (per-cycle state trace, memory handshakes, retire record) into queues; an
// independent monitor pops and compares as the DUT presents cycles, handshakes
// and retirements. Directed sections cover trap, timeout and reset cases.
module tb_multicycle_control_fsm;
  localparam int unsigned TO = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       ir_write, pc_write, reg_write, instret, illegal_instr, bus_error;
  logic [1:0] pc_src, wb_sel, alu_op, alu_src_a, alu_src_b;
  logic [3:0] state_o;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .bus(bus.master), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .instret(instret), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st; logic [1:0] op; logic [1:0] a; logic [1:0] b;
    logic req; logic we; logic sel;
  } trace_t;
  typedef struct packed { logic [1:0] src; logic rw; logic [1:0] wb; logic [7:0] lat; } ret_t;
  typedef struct packed { logic we; logic sel; logic ir; } hs_t;

  trace_t trace_q[$];
  ret_t   ret_q[$];
  hs_t    hs_q[$];
  int     total = 0;
  int     bad   = 0;
  bit     sb_on = 1'b0;
  logic [6:0] op_tab [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic missing(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT event with no expectation queued at %0t", name, $time);
  endtask

  function automatic void push_tr(input logic [3:0] st, input logic [1:0] op, input logic [1:0] a,
                                  input logic [1:0] b, input logic req, input logic we, input logic sel);
    trace_q.push_back({st, op, a, b, req, we, sel});
  endfunction

  // Reference: what one instruction looks like, given the memory wait counts.
  function automatic void expect_instr(input logic [6:0] op, input logic bt, input int wf, input int wa);
    for (int i = 0; i <= wf; i++) push_tr(4'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    hs_q.push_back({1'b0, 1'b0, 1'b1});
    push_tr(4'd1, 2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    case (op)
      OP_R, OP_I, OP_LUI, OP_AUIPC: begin
        if (op == OP_R)        push_tr(4'd2, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        else if (op == OP_I)   push_tr(4'd3, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        else if (op == OP_LUI) push_tr(4'd4, 2'b11, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
        else                   push_tr(4'd4, 2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        push_tr(4'd5, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        ret_q.push_back({2'b00, 1'b1, 2'b00, 8'(4 + wf)});
      end
      OP_LD, OP_ST: begin
        push_tr(4'd6, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= wa; i++) push_tr(4'd7, 2'b00, 2'b00, 2'b00, 1'b1, op == OP_ST, 1'b1);
        hs_q.push_back({op == OP_ST, 1'b1, 1'b0});
        if (op == OP_LD) begin
          push_tr(4'd8, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
          ret_q.push_back({2'b00, 1'b1, 2'b01, 8'(5 + wf + wa)});
        end else begin
          ret_q.push_back({2'b00, 1'b0, 2'b00, 8'(4 + wf + wa)});
        end
      end
      OP_BR: begin
        push_tr(4'd9, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        ret_q.push_back({bt ? 2'b01 : 2'b00, 1'b0, 2'b00, 8'(3 + wf)});
      end
      OP_JAL: begin
        push_tr(4'd10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        ret_q.push_back({2'b01, 1'b1, 2'b10, 8'(3 + wf)});
      end
      OP_JALR: begin
        push_tr(4'd11, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        ret_q.push_back({2'b10, 1'b1, 2'b10, 8'(3 + wf)});
      end
      default: ;
    endcase
  endfunction

  // Monitor: samples every cycle 2 ns after the falling edge.
  initial begin
    int cyc;
    trace_t t;
    ret_t   r;
    hs_t    h;
    cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        cyc = 0;
      end else begin
        cyc++;
        if (sb_on) begin
          if (trace_q.size() == 0) missing("trace");
          else begin
            t = trace_q.pop_front();
            check("trace", 32'({state_o, alu_op, alu_src_a, alu_src_b, bus.mem_req, bus.mem_we, bus.mem_addr_sel}), 32'(t));
          end
          if (bus.mem_req && bus.mem_ready) begin
            if (hs_q.size() == 0) missing("handshake");
            else begin
              h = hs_q.pop_front();
              check("handshake", 32'({bus.mem_we, bus.mem_addr_sel, ir_write}), 32'(h));
            end
          end
          if (instret) begin
            if (ret_q.size() == 0) missing("retire");
            else begin
              r = ret_q.pop_front();
              check("retire", 32'({pc_write, pc_src, reg_write, wb_sel, 8'(cyc)}),
                    32'({1'b1, r.src, r.rw, r.wb, r.lat}));
            end
            cyc = 0;
          end else begin
            check("no_strobe_outside_retire", 32'({pc_write, reg_write}), 32'd0);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one instruction: wf wait cycles on the fetch, wa on the data access.
  task automatic run_instr(input logic [6:0] op, input logic bt, input int wf, input int wa);
    int left;
    int guard;
    bit done;
    bit hs;
    expect_instr(op, bt, wf, wa);
    opcode       = op;
    branch_taken = bt;
    left  = wf;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (left > 0) begin
          bus.mem_ready = 1'b0;
          left--;
        end else begin
          bus.mem_ready = 1'b1;
        end
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      #1;
      hs   = bus.mem_req && bus.mem_ready;
      done = instret;
      @(posedge clk);
      #1;
      if (hs) left = wa;
      guard++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL retire_timeout: opcode %b did not retire within 40 cycles", op);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      #2;
      if (state_o == s) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    bit busy;
    op_tab = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
    rst_n = 1'b0;
    opcode = OP_ST;
    branch_taken = 1'b1;
    bus.mem_ready = 1'b1;
    #12;
    check("reset_outputs", 32'({bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_write, pc_write, pc_src,
                                reg_write, wb_sel, alu_op, alu_src_a, alu_src_b, instret,
                                illegal_instr, bus_error, state_o}), 32'd0);

    // Scoreboarded instruction stream
    do_reset();
    sb_on = 1'b1;
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_LD, 1'b0, 0, 3);
    run_instr(OP_BR, 1'b1, 0, 0);
    run_instr(OP_BR, 1'b0, 0, 0);
    run_instr(OP_ST, 1'b0, 2, 1);
    run_instr(OP_LUI, 1'b0, 0, 0);
    run_instr(OP_AUIPC, 1'b0, 3, 0);
    for (int i = 0; i < 80; i++)
      run_instr(op_tab[$urandom_range(0, 8)], 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    sb_on = 1'b0;
    check("queues_drained", 32'(trace_q.size() + ret_q.size() + hs_q.size()), 32'd0);

    // Illegal opcode traps, stays quiet, and only rst_n clears it
    opcode = 7'b0000000;
    bus.mem_ready = 1'b1;
    do_reset();
    wait_state(4'd15, 10, ok);
    check("illegal_reach_trap", 32'(ok), 32'd1);
    check("illegal_flags", 32'({illegal_instr, bus_error}), 32'b10);
    busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #2;
      if (bus.mem_req || pc_write || reg_write || instret || ir_write) busy = 1'b1;
    end
    check("trap_quiet", 32'(busy), 32'd0);
    check("illegal_sticky", 32'({illegal_instr, state_o}), 32'({1'b1, 4'd15}));
    do_reset();
    @(negedge clk);
    #2;
    check("illegal_cleared", 32'({illegal_instr, state_o}), 32'd0);

    // Fetch timeout after 4 wait cycles
    opcode = OP_R;
    bus.mem_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    #2;
    check("timeout_cycle4", 32'({bus_error, state_o, bus.mem_req}), 32'({1'b0, 4'd0, 1'b1}));
    @(negedge clk);
    #2;
    check("timeout_trap", 32'({bus_error, state_o, bus.mem_req}), 32'({1'b1, 4'd15, 1'b0}));

    // Ready arriving in the 4th wait cycle wins
    do_reset();
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #2;
    check("rescue_ir_write", 32'({ir_write, bus_error}), 32'b10);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    check("rescue_no_error", 32'({bus_error, state_o}), 32'({1'b0, 4'd1}));

    // Reset asserted while a store waits in MEM_ACC
    opcode = OP_ST;
    bus.mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    wait_state(4'd7, 10, ok);
    check("store_reach_acc", 32'(ok), 32'd1);
    check("store_acc_bus", 32'({bus.mem_req, bus.mem_we, bus.mem_addr_sel}), 32'b111);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_access", 32'({bus.mem_req, pc_write, instret, state_o}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("after_rst_fetch", 32'({state_o, bus.mem_req, bus.mem_we, bus.mem_addr_sel}),
          32'({4'd0, 1'b1, 1'b0, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
